screen_flow_controller: RTL and testbench
=========================================

# screen_flow_controller

Sequential game-flow controller that produces the `is_in_menu` level consumed by the screen router and acts on the router's `current_screen` code. It runs the start countdown, clears player positions, holds the finished screen for a fixed time, and handles an abort long-press. It sits between the button front-end, the player position counters and the router, closing the loop from screen code back to menu state.

## Interface
- `COUNT_TICKS`, default 1000: ticks per countdown step (3→2→1).
- `HOLD_TICKS`, default 5000: ticks the finished screen is held before auto-return to menu.
- `ABORT_TICKS`, default 2000: ticks `start_btn` must stay high during play to abort.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `tick`  in  1  one-cycle timebase enable; all timers advance only on `tick`.
- `start_btn`  in  1  debounced, synchronised start button level.
- `current_screen`  in  2  router code: 00 menu, 01 race in progress, 10 finished, 11 armed with no movement.
- `is_in_menu`  out  1  registered; drives the router and the player counters.
- `positions_clear`  out  1  one-cycle pulse; player counters reset positions to 0.
- `countdown_value`  out  2  3, 2 or 1 during countdown; 0 otherwise.
- `finish_hold`  out  1  high while in FINISHED.

## Operation
- States: MENU, COUNTDOWN, PLAY, FINISHED.
- `start_rise` = `start_btn` & ~registered previous `start_btn`. The edge register resets to 1, so a button held through reset produces no edge.
- MENU: `is_in_menu`=1. On `start_rise` go to COUNTDOWN, load `countdown_value`=3, clear timer, pulse `positions_clear`.
- COUNTDOWN: `is_in_menu`=1.
  - Each `tick` increments the timer. On the tick where timer = COUNT_TICKS-1, clear the timer and decrement `countdown_value`.
  - When that decrement would take 1→0, go to PLAY instead.
  - `start_rise` is ignored in this state.
- PLAY: `is_in_menu`=0, `countdown_value`=0.
  - `current_screen`=10 moves to FINISHED and clears the timer.
  - Abort is armed by a `start_rise` seen in PLAY. While armed and `start_btn`=1, count ticks. At ABORT_TICKS, go to MENU and pulse `positions_clear`.
  - `start_btn`=0 disarms the abort and clears the abort count.
  - `current_screen`=00 cannot occur in PLAY. If it does, go to MENU and pulse `positions_clear`.
- FINISHED: `is_in_menu`=0, `finish_hold`=1.
  - Go to MENU and pulse `positions_clear` on whichever comes first: `start_rise`, or the tick where timer = HOLD_TICKS-1.
  - If both occur in the same cycle, the transition happens once and the pulse lasts one cycle.
- Timer width = `$clog2(max(COUNT_TICKS, HOLD_TICKS, ABORT_TICKS)+1)`; it saturates and never wraps. The abort count reuses the same timer, which is idle in PLAY.

## Timing
- Reset values: state MENU, `is_in_menu`=1, `positions_clear`=0, `countdown_value`=0, `finish_hold`=0, timer 0, abort disarmed. Reset does not pulse `positions_clear`.
- Reset mid-operation: the next cycle returns to MENU with the reset values.
- All outputs are registered. A transition decided in cycle N is visible in cycle N+1, together with any `positions_clear` pulse.
- Countdown length is exactly 3×COUNT_TICKS ticks from entry to PLAY.
- `positions_clear` fires on COUNTDOWN entry, so positions are already 0 when `is_in_menu` falls. The router therefore never sees stale positions with `is_in_menu`=0.
- `current_screen` is sampled every cycle and needs no `tick`. Its 1-cycle combinational lag after an `is_in_menu` change is tolerated: FINISHED is entered only from PLAY, and only on code 10.

## Structure
- Shared package `screen_pkg`:
  - screen code localparams: SCREEN_MENU=2'b00, SCREEN_RACE=2'b01, SCREEN_FINISHED=2'b10, SCREEN_ARMED=2'b11;
  - the flow state encoding (2 bits).
- The router also imports `screen_pkg`.
- One sub-module, `tick_timer`:
  - ports: clear, enable (`tick`), target;
  - outputs: `done` (combinational, true on the tick where count = target-1) and a saturating count.
  - One instance, shared by the countdown, hold and abort timing.

## Test plan
Use COUNT_TICKS=2, HOLD_TICKS=3, ABORT_TICKS=4, `tick`=1 every cycle.
- Reset with `start_btn` held high, then keep it high: `is_in_menu`=1, state stays MENU, no `positions_clear`.
- `start_btn` 0→1 in MENU at cycle 0:
  - cycle 1: `positions_clear`=1, `countdown_value`=3;
  - cycle 3: `countdown_value`=2; cycle 5: 1;
  - cycle 7: `is_in_menu`=0, `countdown_value`=0.
- In PLAY, drive `current_screen`=10 at cycle 0:
  - cycle 1: `finish_hold`=1;
  - cycle 4: MENU, `is_in_menu`=1, `positions_clear`=1 for exactly one cycle.
- In FINISHED, assert `start_rise` on the same cycle as hold expiry: a single MENU entry with a single-cycle `positions_clear`.
- In PLAY:
  - press and hold `start_btn` from cycle 0: MENU and `positions_clear` at cycle 5;
  - repeat with a release at cycle 2: stays in PLAY.
- Drop `rst_n` for one cycle during COUNTDOWN with `countdown_value`=2: next cycle all outputs at reset values, and no `positions_clear` is seen.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared definitions for the screen router and the game-flow controller:
// router screen codes, the flow state encoding and a small sizing helper.
package screen_pkg;

   localparam logic [1:0] SCREEN_MENU     = 2'b00;
   localparam logic [1:0] SCREEN_RACE     = 2'b01;
   localparam logic [1:0] SCREEN_FINISHED = 2'b10;
   localparam logic [1:0] SCREEN_ARMED    = 2'b11;

   typedef enum logic [1:0] {
      FLOW_MENU      = 2'b00,
      FLOW_COUNTDOWN = 2'b01,
      FLOW_PLAY      = 2'b10,
      FLOW_FINISHED  = 2'b11
   } flow_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/tick_timer.sv
// Saturating tick counter with a combinational "last tick before target" flag.
// Shared by the countdown steps, the finished-screen hold and the abort press.
module tick_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] target,
   output logic             done,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] COUNT_MAX = '1;

   // done marks the tick on which the count would reach target.
   assign done = enable && (count == (target - ONE));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != COUNT_MAX)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/screen_flow_controller.sv
// Game-flow FSM: start countdown, position clearing, finished-screen hold and
// abort long-press, producing the registered is_in_menu level for the router.
module screen_flow_controller
   import screen_pkg::*;
#(
   parameter int COUNT_TICKS = 1000,
   parameter int HOLD_TICKS  = 5000,
   parameter int ABORT_TICKS = 2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       start_btn,
   input  logic [1:0] current_screen,
   output logic       is_in_menu,
   output logic       positions_clear,
   output logic [1:0] countdown_value,
   output logic       finish_hold
);

   localparam int TW = $clog2(max3(COUNT_TICKS, HOLD_TICKS, ABORT_TICKS) + 1);
   localparam logic [TW-1:0] COUNT_T = TW'(COUNT_TICKS);
   localparam logic [TW-1:0] HOLD_T  = TW'(HOLD_TICKS);
   localparam logic [TW-1:0] ABORT_T = TW'(ABORT_TICKS);

   flow_state_t   state, state_next;
   logic [1:0]    countdown_next;
   logic          armed, armed_next;
   logic          prev_btn;
   logic          start_rise;
   logic          clear_next;
   logic          timer_clear, timer_enable, timer_done;
   logic [TW-1:0] timer_target, timer_count;

   assign start_rise = start_btn & ~prev_btn;

   tick_timer #(.WIDTH(TW)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (timer_clear),
      .enable (timer_enable),
      .target (timer_target),
      .done   (timer_done),
      .count  (timer_count)
   );

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_next     = state;
      countdown_next = countdown_value;
      armed_next     = armed;
      clear_next     = 1'b0;
      timer_clear    = 1'b0;
      timer_enable   = 1'b0;
      timer_target   = COUNT_T;

      case (state)
         FLOW_MENU: begin
            timer_clear    = 1'b1;
            countdown_next = 2'd0;
            if (start_rise) begin
               state_next     = FLOW_COUNTDOWN;
               countdown_next = 2'd3;
               clear_next     = 1'b1;
            end
         end

         FLOW_COUNTDOWN: begin
            timer_enable = tick;
            if (timer_done) begin
               timer_clear = 1'b1;
               if (countdown_value == 2'd1) begin
                  state_next     = FLOW_PLAY;
                  countdown_next = 2'd0;
               end else begin
                  countdown_next = countdown_value - 2'd1;
               end
            end
         end

         FLOW_PLAY: begin
            timer_target = ABORT_T;
            timer_enable = tick & armed & start_btn;
            if (current_screen == SCREEN_FINISHED) begin
               state_next  = FLOW_FINISHED;
               timer_clear = 1'b1;
               armed_next  = 1'b0;
            end else if ((current_screen == SCREEN_MENU) || timer_done) begin
               state_next  = FLOW_MENU;
               clear_next  = 1'b1;
               timer_clear = 1'b1;
               armed_next  = 1'b0;
            end else if (!start_btn) begin
               // Releasing the button throws away any partial abort count.
               armed_next  = 1'b0;
               timer_clear = (timer_count != '0);
            end else if (start_rise) begin
               armed_next = 1'b1;
            end
         end

         FLOW_FINISHED: begin
            timer_target = HOLD_T;
            timer_enable = tick;
            if (start_rise || timer_done) begin
               state_next  = FLOW_MENU;
               clear_next  = 1'b1;
               timer_clear = 1'b1;
            end
         end

         default: state_next = FLOW_MENU;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= FLOW_MENU;
         armed           <= 1'b0;
         prev_btn        <= 1'b1;
         is_in_menu      <= 1'b1;
         positions_clear <= 1'b0;
         countdown_value <= 2'd0;
         finish_hold     <= 1'b0;
      end else begin
         state           <= state_next;
         armed           <= armed_next;
         prev_btn        <= start_btn;
         is_in_menu      <= (state_next == FLOW_MENU) || (state_next == FLOW_COUNTDOWN);
         positions_clear <= clear_next;
         countdown_value <= countdown_next;
         finish_hold     <= (state_next == FLOW_FINISHED);
      end
   end

endmodule

// File: tb/tb_screen_flow_controller.sv
// Self-checking bench for screen_flow_controller: directed scenarios followed
// by randomized stimulus, all compared against a tick-counting behavioural model.
module tb_screen_flow_controller;

   localparam int CT = 2;
   localparam int HT = 3;
   localparam int AT = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b1;
   logic       start_btn = 1'b0;
   logic [1:0] current_screen = 2'b01;
   logic       is_in_menu, positions_clear, finish_hold;
   logic [1:0] countdown_value;

   int checks   = 0;
   int failures = 0;

   screen_flow_controller #(
      .COUNT_TICKS (CT),
      .HOLD_TICKS  (HT),
      .ABORT_TICKS (AT)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .tick            (tick),
      .start_btn       (start_btn),
      .current_screen  (current_screen),
      .is_in_menu      (is_in_menu),
      .positions_clear (positions_clear),
      .countdown_value (countdown_value),
      .finish_hold     (finish_hold)
   );

   always #5 clk = ~clk;

   // Behavioural model: phase plus ticks elapsed in that phase.
   typedef enum {M_IDLE, M_COUNT, M_RACE, M_DONE} mode_t;
   mode_t m_mode = M_IDLE;
   int    m_ticks = 0;
   bit    m_armed = 0;
   bit    m_prev = 1;
   bit    e_pulse = 0;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit t, input bit b, input logic [1:0] s);
      bit rise;
      if (!r) begin
         m_mode = M_IDLE; m_ticks = 0; m_armed = 0; m_prev = 1; e_pulse = 0;
         return;
      end
      rise    = b && !m_prev;
      m_prev  = b;
      e_pulse = 0;
      case (m_mode)
         M_IDLE: if (rise) begin m_mode = M_COUNT; m_ticks = 0; e_pulse = 1; end
         M_COUNT: begin
            if (t) m_ticks++;
            if (m_ticks == 3 * CT) begin m_mode = M_RACE; m_ticks = 0; end
         end
         M_RACE: begin
            if (s == 2'b10) begin
               m_mode = M_DONE; m_ticks = 0; m_armed = 0;
            end else if (s == 2'b00) begin
               m_mode = M_IDLE; m_ticks = 0; m_armed = 0; e_pulse = 1;
            end else if (!b) begin
               m_armed = 0; m_ticks = 0;
            end else if (m_armed) begin
               if (t) m_ticks++;
               if (m_ticks == AT) begin m_mode = M_IDLE; m_ticks = 0; m_armed = 0; e_pulse = 1; end
            end else if (rise) begin
               m_armed = 1;
            end
         end
         M_DONE: begin
            if (t) m_ticks++;
            if (rise || (t && m_ticks == HT)) begin m_mode = M_IDLE; m_ticks = 0; e_pulse = 1; end
         end
      endcase
   endtask

   task automatic cycle(input bit r, input bit t, input bit b, input logic [1:0] s);
      int e_cd;
      rst_n = r; tick = t; start_btn = b; current_screen = s;
      @(posedge clk);
      model_step(r, t, b, s);
      #1;
      e_cd = (m_mode == M_COUNT) ? 3 - m_ticks / CT : 0;
      check("is_in_menu", 32'(is_in_menu), 32'(m_mode == M_IDLE || m_mode == M_COUNT));
      check("positions_clear", 32'(positions_clear), 32'(e_pulse));
      check("countdown_value", 32'(countdown_value), 32'(e_cd));
      check("finish_hold", 32'(finish_hold), 32'(m_mode == M_DONE));
   endtask

   // From MENU with the button released, press and hold until PLAY is reached.
   task automatic go_play();
      cycle(1, 1, 0, 2'b01);
      cycle(1, 1, 1, 2'b01);
      repeat (6) cycle(1, 1, 1, 2'b01);
      check("go_play_in_menu", 32'(is_in_menu), 32'd0);
   endtask

   initial begin
      // Reset with the button held, then keep holding: no edge, no clear.
      cycle(0, 1, 1, 2'b01);
      cycle(0, 1, 1, 2'b01);
      check("rst_in_menu", 32'(is_in_menu), 32'd1);
      check("rst_clear", 32'(positions_clear), 32'd0);
      repeat (4) cycle(1, 1, 1, 2'b01);
      check("held_in_menu", 32'(is_in_menu), 32'd1);
      check("held_no_countdown", 32'(countdown_value), 32'd0);

      // Countdown timing.
      cycle(1, 1, 0, 2'b01);
      cycle(1, 1, 1, 2'b01);
      check("cd_c1_clear", 32'(positions_clear), 32'd1);
      check("cd_c1_value", 32'(countdown_value), 32'd3);
      cycle(1, 1, 1, 2'b01);
      cycle(1, 1, 1, 2'b01);
      check("cd_c3_value", 32'(countdown_value), 32'd2);
      cycle(1, 1, 1, 2'b01);
      cycle(1, 1, 1, 2'b01);
      check("cd_c5_value", 32'(countdown_value), 32'd1);
      cycle(1, 1, 1, 2'b01);
      cycle(1, 1, 1, 2'b01);
      check("cd_c7_menu", 32'(is_in_menu), 32'd0);
      check("cd_c7_value", 32'(countdown_value), 32'd0);

      // Finished screen held, then auto-return.
      cycle(1, 1, 0, 2'b10);
      check("fin_c1_hold", 32'(finish_hold), 32'd1);
      repeat (3) cycle(1, 1, 0, 2'b10);
      check("fin_c4_menu", 32'(is_in_menu), 32'd1);
      check("fin_c4_clear", 32'(positions_clear), 32'd1);
      cycle(1, 1, 0, 2'b00);
      check("fin_c5_clear", 32'(positions_clear), 32'd0);

      // Hold expiry coinciding with a start edge.
      go_play();
      cycle(1, 1, 0, 2'b10);
      cycle(1, 1, 0, 2'b10);
      cycle(1, 1, 0, 2'b10);
      cycle(1, 1, 1, 2'b10);
      check("both_c4_clear", 32'(positions_clear), 32'd1);
      cycle(1, 1, 1, 2'b00);
      check("both_c5_clear", 32'(positions_clear), 32'd0);
      check("both_c5_menu", 32'(is_in_menu), 32'd1);
      check("both_c5_value", 32'(countdown_value), 32'd0);

      // Abort long-press.
      go_play();
      cycle(1, 1, 0, 2'b01);
      repeat (4) cycle(1, 1, 1, 2'b01);
      check("abort_c4_play", 32'(is_in_menu), 32'd0);
      cycle(1, 1, 1, 2'b01);
      check("abort_c5_menu", 32'(is_in_menu), 32'd1);
      check("abort_c5_clear", 32'(positions_clear), 32'd1);

      // Abort press released early.
      go_play();
      cycle(1, 1, 0, 2'b01);
      cycle(1, 1, 1, 2'b01);
      cycle(1, 1, 1, 2'b01);
      repeat (6) cycle(1, 1, 0, 2'b01);
      check("release_stays_play", 32'(is_in_menu), 32'd0);

      // Reset during countdown at value 2.
      cycle(1, 1, 0, 2'b10);
      repeat (3) cycle(1, 1, 0, 2'b10);
      cycle(1, 1, 1, 2'b00);
      cycle(1, 1, 1, 2'b00);
      cycle(1, 1, 1, 2'b00);
      check("pre_rst_value", 32'(countdown_value), 32'd2);
      cycle(0, 1, 1, 2'b00);
      check("mid_rst_value", 32'(countdown_value), 32'd0);
      check("mid_rst_clear", 32'(positions_clear), 32'd0);
      check("mid_rst_menu", 32'(is_in_menu), 32'd1);
      cycle(1, 1, 1, 2'b00);
      check("post_rst_clear", 32'(positions_clear), 32'd0);

      // Randomized stimulus.
      begin
         bit b = 0;
         for (int i = 0; i < 4000; i++) begin
            int sr;
            logic [1:0] s;
            if ($urandom_range(0, 9) == 0) b = ~b;
            sr = $urandom_range(0, 99);
            s  = (sr < 2) ? 2'b00 : (sr < 8) ? 2'b10 : (sr < 12) ? 2'b11 : 2'b01;
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), b, s);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
